instr_fetch: RTL and testbench

- Instruction source for `cpu`: holds a small program memory and issues 32-bit instruction words to the core's `in` port over a valid/ready handshake.
- Maintains a byte-addressed PC, accepts redirects from the core, and halts on a sentinel word.
- Replaces hand-driven instruction stimulus; it is the producer end of the `in` interface.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_fetch_imem.sv | 37 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu instruction-fetch front end.
//   fetch_state_e : instruction-fetch FSM states
//   XLEN          : instruction/data word width
//   HALT_WORD     : fetched value that stops issue (never delivered to the core)
//   OP_R / OP_I   : RV32 opcode fields, handy when building program words
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int          XLEN      = 32;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;

endpackage

// File: rtl/instr_fetch_imem.sv
// imem: DEPTH x 32 program memory.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset (read register only; array is not reset)
//   we     : write enable, writes wdata to mem[waddr] on the clock edge
//   waddr  : write word address
//   wdata  : write data
//   re     : read enable, captures mem[raddr] into rdata on the clock edge
//   raddr  : read word address
//   rdata  : registered read data, holds its value while re is low
module imem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the instruction output holding register,
  // so it is reset and only updated when a read is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program memory plus fetch FSM feeding the core's instruction port.
//   clk, rst          : clock, asynchronous active-low reset
//   load_en/addr/data : program load port, honoured only in IDLE
//   start             : begin fetching from PC 0 (IDLE or DONE)
//   redirect_en/pc    : core-requested PC change (byte address, bits [1:0] ignored)
//   instr_out         : instruction word, qualified by instr_valid
//   instr_valid       : instr_out holds an unconsumed instruction
//   instr_ready       : core accepts instr_out this cycle
//   pc                : byte address of the current/next fetch
//   busy, done        : FSM in FETCH/ISSUE, FSM in DONE
//   issued_cnt        : instructions accepted since last start (saturating)
module instr_fetch #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [31:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          redirect_en,
  input  logic [AW+1:0] redirect_pc,
  output logic [31:0]   instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW+1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   issued_cnt
);
  import cpu_pkg::*;

  localparam int PCW = AW + 2;

  fetch_state_e   state, state_nxt;
  logic [PCW-1:0] pc_nxt;
  logic [15:0]    cnt_nxt;
  logic           rd_en;
  logic           mem_we;
  logic [31:0]    rd_data;
  logic [AW-1:0]  pc_word;
  logic [PCW-1:0] pc_redir;
  logic           is_halt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pc_word  = pc[AW+1:2];
  assign pc_redir = redirect_pc & ~PCW'(3);
  assign mem_we   = load_en && (state == IDLE);
  assign is_halt  = (rd_data == HALT_WORD);

  imem #(.DEPTH(DEPTH), .AW(AW)) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (pc_word),
    .rdata (rd_data)
  );

  assign instr_out   = rd_data;
  assign instr_valid = (state == ISSUE) && !is_halt;
  assign busy        = (state == FETCH) || (state == ISSUE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      issued_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      issued_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = issued_cnt;
    rd_en     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        if (redirect_en) begin
          pc_nxt = pc_redir;
        end else begin
          rd_en     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Redirect wins over a same-cycle handshake: the held word is dropped.
        if (redirect_en) begin
          pc_nxt    = pc_redir;
          state_nxt = FETCH;
        end else if (is_halt) begin
          state_nxt = DONE;
        end else if (instr_ready) begin
          cnt_nxt = sat_inc16(issued_cnt);
          // Running off the end of memory stops instead of wrapping to word 0.
          if (pc_word == AW'(DEPTH - 1)) begin
            state_nxt = DONE;
          end else begin
            pc_nxt    = pc + PCW'(4);
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] W1 = 32'h0020_81B3;
  localparam logic [31:0] W2 = 32'h0630_0F13;
  localparam logic [31:0] W3 = 32'h0108_03B3;

  logic        clk, rst;
  logic        load_en, start, redirect_en, instr_ready;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [5:0]  redirect_pc;
  logic [31:0] instr_out;
  logic        instr_valid, busy, done;
  logic [5:0]  pc;
  logic [15:0] issued_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fw [16];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step(1);
      k++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  // Scoreboard: every accepted instruction must match the next expected word,
  // and a valid instruction must never be the halt sentinel.
  always @(negedge clk) begin
    if (rst === 1'b1 && instr_valid === 1'b1) begin
      chk("valid_not_halt", 32'(instr_out != HALT_WORD), 32'd1);
      if (instr_ready && !redirect_en) begin
        if (exp_q.size() == 0) chk("unexpected_issue", instr_out, 32'hxxxx_xxxx);
        else chk("issue_word", instr_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; load_en = 0; load_addr = 0; load_data = 0; start = 0;
    redirect_en = 0; redirect_pc = 0; instr_ready = 0;
    #3 rst = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(issued_cnt), 0);
    chk("rst_instr", instr_out, 0);
    #9 rst = 1'b1;
    step(1);

    // Basic program
    load(4'd0, W1); load(4'd1, W2); load(4'd2, W3); load(4'd3, 32'h0);
    exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    instr_ready = 1'b1;
    pulse_start();
    chk("basic_fetch_valid", 32'(instr_valid), 0);
    chk("basic_fetch_busy", 32'(busy), 1);
    step(1);
    chk("basic_issue_valid", 32'(instr_valid), 1);
    chk("basic_issue_word", instr_out, W1);
    step(1);
    chk("basic_gap_valid", 32'(instr_valid), 0);
    run_until_done(40);
    chk("basic_cnt", 32'(issued_cnt), 3);
    chk("basic_pc", 32'(pc), 12);
    chk("basic_q_empty", 32'(exp_q.size()), 0);

    // Backpressure on the second word
    exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    pulse_start();
    step(2);
    instr_ready = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_word", instr_out, W2);
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_pc", 32'(pc), 4);
      chk("bp_cnt", 32'(issued_cnt), 1);
      step(1);
    end
    instr_ready = 1'b1;
    run_until_done(40);
    chk("bp_cnt_final", 32'(issued_cnt), 3);

    // Redirect priority over handshake, and low address bits ignored
    exp_q.push_back(W1);
    pulse_start();
    step(3);
    chk("rd_w2_valid", 32'(instr_valid), 1);
    chk("rd_w2_word", instr_out, W2);
    redirect_en = 1'b1; redirect_pc = 6'h00;
    exp_q.push_back(W1);
    step(1);
    redirect_en = 1'b0;
    chk("rd_pc0", 32'(pc), 0);
    chk("rd_cnt_not_counted", 32'(issued_cnt), 1);
    step(2);
    chk("rd_cnt_after_w1", 32'(issued_cnt), 2);
    step(1);
    redirect_en = 1'b1; redirect_pc = 6'h05;
    step(1);
    redirect_en = 1'b0;
    chk("rd_pc5_as_4", 32'(pc), 4);
    chk("rd_cnt_hold", 32'(issued_cnt), 2);
    exp_q.push_back(W2); exp_q.push_back(W3);
    run_until_done(40);
    chk("rd_cnt_final", 32'(issued_cnt), 4);
    chk("rd_pc_final", 32'(pc), 12);
    chk("rd_q_empty", 32'(exp_q.size()), 0);

    // Load gating while busy / done
    exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    pulse_start();
    load_en = 1'b1; load_addr = 4'd0; load_data = 32'hDEAD_BEEF;
    run_until_done(40);
    step(2);
    load_en = 1'b0;
    exp_q.push_back(W1);
    pulse_start();
    step(2);
    chk("gate_q_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of FETCH
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_cnt", 32'(issued_cnt), 0);
    rst = 1'b1;
    step(1);
    exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    pulse_start();
    run_until_done(40);
    chk("post_rst_cnt", 32'(issued_cnt), 3);

    // Full memory, with load of word 0 in the same cycle as start
    rst = 1'b0; #1; rst = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++)
      fw[i] = {12'(i + 1), 5'(i), 3'b000, 5'(i + 1), OP_I};
    for (int i = 1; i < 16; i++) load(4'(i), fw[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(fw[i]);
    load_en = 1'b1; load_addr = 4'd0; load_data = fw[0]; start = 1'b1;
    step(1);
    load_en = 1'b0; start = 1'b0;
    run_until_done(100);
    chk("full_pc", 32'(pc), 60);
    chk("full_cnt", 32'(issued_cnt), 16);
    chk("full_q_empty", 32'(exp_q.size()), 0);
    step(4);
    chk("full_no_reissue", 32'(instr_valid), 0);
    chk("full_done_hold", 32'(done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
